dijkstra_mem_bridge: RTL and testbench
======================================

# dijkstra_mem_bridge

Converts the Dijkstra core's simple level-request memory port into Avalon-MM master transactions: latches address and data, honours waitrequest and readdatavalid, and bounds every access with a timeout. It sits directly downstream of the Dijkstra core's memory port, between the core and the system interconnect. It also keeps sticky error status and access counters for software debug.

## Interface
- MADDR_WIDTH, 32, byte address width
- MDATA_WIDTH, 16, data width; must be a multiple of 8
- TIMEOUT_CYCLES, 1024, per-access cycle limit; minimum 4
- CNT_WIDTH, 32, width of the statistics counters

- algorithm_clock in 1: sole clock
- algorithm_reset in 1: synchronous, active-high
- core_read_enable in 1: read request; level, held until core_read_ready
- core_write_enable in 1: write request; level, held until core_write_ready
- core_addr in MADDR_WIDTH: request address
- core_write_data in MDATA_WIDTH: write data
- core_read_data out MDATA_WIDTH: read result; valid while core_read_ready=1, holds afterwards
- core_read_ready out 1: one-cycle completion pulse for a read
- core_write_ready out 1: one-cycle completion pulse for a write
- avm_address out MADDR_WIDTH: Avalon address
- avm_read out 1: Avalon read command
- avm_write out 1: Avalon write command
- avm_writedata out MDATA_WIDTH: Avalon write data
- avm_byteenable out MDATA_WIDTH/8: all ones whenever a command is asserted, 0 otherwise
- avm_waitrequest in 1: slave stall
- avm_readdata in MDATA_WIDTH: slave read data
- avm_readdatavalid in 1: read data qualifier
- error_clear in 1: clears timeout_error
- stats_clear in 1: zeroes both counters
- timeout_error out 1: sticky; set by any timeout
- read_count out CNT_WIDTH: completed reads, timeouts included
- write_count out CNT_WIDTH: completed writes, timeouts included

## Operation
- FSM states: IDLE, RD_CMD, RD_DATA, WR_CMD, RESP.
- **IDLE**
  - read_enable=1: latch core_addr and go to RD_CMD.
  - Otherwise, write_enable=1: latch core_addr and core_write_data and go to WR_CMD.
  - Read has priority when both are high. The write stays pending because the core holds its enable.
- **RD_CMD**
  - avm_read=1 and avm_address=latched address, both registered.
  - A command is accepted in the cycle avm_read=1 and waitrequest=0. On acceptance go to RD_DATA.
- **RD_DATA**
  - On avm_readdata­valid=1, capture avm_readdata into core_read_data and go to RESP.
  - readdatavalid in any other state is ignored and discarded.
- **WR_CMD**
  - avm_write=1 with latched address and data.
  - On acceptance go to RESP. There is no write response.
- **RESP**
  - Pulse core_read_ready or core_write_ready for exactly one cycle.
  - Increment the matching counter and return to IDLE.
- **Timeout**
  - A counter is cleared on leaving IDLE and increments each cycle in RD_CMD, RD_DATA and WR_CMD.
  - When it reaches TIMEOUT_CYCLES-1 without progress, the access is abandoned: commands drop, timeout_error is set, and the FSM goes to RESP.
  - For an abandoned read, core_read_data is all ones.
- **Commands and counters**
  - Commands are held stable (address, data, byteenable) while waitrequest=1.
  - Counters wrap at 2^CNT_WIDTH.
  - stats_clear wins over a same-cycle increment.
  - error_clear loses to a same-cycle timeout; the flag stays 1.

## Timing
- Reset values: all outputs 0, except core_read_data=0 and avm_byteenable=0. FSM returns to IDLE.
- Reset mid-access drops any asserted command immediately and produces no ready pulse. A late readdatavalid after reset is ignored.
- Read latency with zero wait states and readdatavalid one cycle after acceptance:
  - request seen in IDLE at cycle 0
  - avm_read at cycle 1
  - readdatavalid at cycle 2
  - core_read_ready at cycle 3
- Write latency with zero wait states: request at cycle 0, avm_write at cycle 1, core_write_ready at cycle 2.
- Each added waitrequest or readdatavalid delay cycle adds exactly one cycle.
- Only one transaction is outstanding at a time.
- The core must drop or change its request in the ready cycle. An enable still high in the cycle after the pulse is a new request.
- readdatavalid in the same cycle as acceptance is not legal for this slave; the bridge is not required to handle it.

## Test plan
- **Read, zero wait:** read_enable at addr 0x1000, readdata=0x00AB one cycle after acceptance -> avm_read high for 1 cycle, core_read_ready at cycle 3, core_read_data=0x00AB, read_count=1.
- **Write with 3 waitrequest cycles:** write 0x1234 to 0x2002 -> avm_write held 4 cycles with stable address and data, core_write_ready at cycle 5, write_count=1.
- **Simultaneous requests:** read and write both high -> read completes first, then the write issues in the cycle after the read pulse.
- **Timeout:** waitrequest stuck high with TIMEOUT_CYCLES=8 -> avm_read drops after 8 cycles, core_read_ready pulses with data 0xFFFF, timeout_error=1. A late readdatavalid is ignored. error_clear returns the flag to 0.
- **Reset mid-read:** reset asserted in RD_DATA -> avm_read=0, no ready pulse, counters 0. A following readdatavalid produces no effect.
- **Counters:** stats_clear in the same cycle as a RESP increment -> count=0.

Source files
------------

// File: rtl/dijkstra_mem_bridge_if.sv
// Avalon-MM master port bundle between the Dijkstra memory bridge and the system interconnect.
interface dijkstra_mem_bridge_if #(
  parameter int MADDR_WIDTH = 32,
  parameter int MDATA_WIDTH = 16
);
  logic [MADDR_WIDTH-1:0]   address;
  logic                     read;
  logic                     write;
  logic [MDATA_WIDTH-1:0]   writedata;
  logic [MDATA_WIDTH/8-1:0] byteenable;
  logic                     waitrequest;
  logic [MDATA_WIDTH-1:0]   readdata;
  logic                     readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/dijkstra_mem_bridge.sv
// Bridges the Dijkstra core's level-request memory port to a single-outstanding Avalon-MM master,
// with a per-access timeout, sticky timeout flag and completed-access counters.
module dijkstra_mem_bridge #(
  parameter int MADDR_WIDTH    = 32,
  parameter int MDATA_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                   algorithm_clock,
  input  logic                   algorithm_reset,
  input  logic                   core_read_enable,
  input  logic                   core_write_enable,
  input  logic [MADDR_WIDTH-1:0] core_addr,
  input  logic [MDATA_WIDTH-1:0] core_write_data,
  output logic [MDATA_WIDTH-1:0] core_read_data,
  output logic                   core_read_ready,
  output logic                   core_write_ready,
  dijkstra_mem_bridge_if.master  avm,
  input  logic                   error_clear,
  input  logic                   stats_clear,
  output logic                   timeout_error,
  output logic [CNT_WIDTH-1:0]   read_count,
  output logic [CNT_WIDTH-1:0]   write_count
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_CMD, RESP} state_t;

  state_t                 state, state_next;
  logic [TW-1:0]          tcnt;
  logic                   is_read;
  logic                   timeout_hit;
  logic                   rd_capture;
  logic                   cmd_read, cmd_write;
  logic [MADDR_WIDTH-1:0] addr_q;
  logic [MDATA_WIDTH-1:0] wdata_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge algorithm_clock) begin
    if (algorithm_reset) state <= IDLE;
    else                 state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    rd_capture  = 1'b0;
    case (state)
      IDLE: begin
        if (core_read_enable)       state_next = RD_CMD;
        else if (core_write_enable) state_next = WR_CMD;
      end
      RD_CMD: begin
        if (!avm.waitrequest) state_next = RD_DATA;
        else if (tcnt == T_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RD_DATA: begin
        if (avm.readdatavalid) begin
          rd_capture = 1'b1;
          state_next = RESP;
        end else if (tcnt == T_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      WR_CMD: begin
        if (!avm.waitrequest) state_next = RESP;
        else if (tcnt == T_LAST) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge algorithm_clock) begin
    if (algorithm_reset) begin
      cmd_read       <= 1'b0;
      cmd_write      <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      is_read        <= 1'b0;
      tcnt           <= '0;
      core_read_data <= '0;
      timeout_error  <= 1'b0;
      read_count     <= '0;
      write_count    <= '0;
    end else begin
      // Commands are decoded from the next state so they are registered yet align with the FSM.
      cmd_read  <= (state_next == RD_CMD);
      cmd_write <= (state_next == WR_CMD);

      if (state == IDLE) begin
        tcnt    <= '0;
        is_read <= core_read_enable;
        if (core_read_enable) begin
          addr_q <= core_addr;
        end else if (core_write_enable) begin
          addr_q  <= core_addr;
          wdata_q <= core_write_data;
        end
      end else if (state != RESP) begin
        tcnt <= tcnt + TW'(1);
      end

      if (rd_capture)                core_read_data <= avm.readdata;
      else if (timeout_hit && is_read) core_read_data <= '1;

      if (timeout_hit)      timeout_error <= 1'b1;
      else if (error_clear) timeout_error <= 1'b0;

      if (stats_clear) begin
        read_count  <= '0;
        write_count <= '0;
      end else if (state == RESP) begin
        if (is_read) read_count  <= read_count + CNT_WIDTH'(1);
        else         write_count <= write_count + CNT_WIDTH'(1);
      end
    end
  end

  assign core_read_ready  = (state == RESP) &&  is_read;
  assign core_write_ready = (state == RESP) && !is_read;

  assign avm.address    = addr_q;
  assign avm.writedata  = wdata_q;
  assign avm.read       = cmd_read;
  assign avm.write      = cmd_write;
  assign avm.byteenable = (cmd_read || cmd_write) ? '1 : '0;
endmodule

// File: tb/tb_dijkstra_mem_bridge.sv
// Directed bench for dijkstra_mem_bridge: drives the core port and plays the Avalon slave,
// checking completions against a scoreboard of expected responses.
module tb_dijkstra_mem_bridge;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int CW = 32;

  typedef struct {
    bit          is_read;
    logic [15:0] data;
    int          cycle;
  } resp_t;

  logic          algorithm_clock = 1'b0;
  logic          algorithm_reset;
  logic          core_read_enable, core_write_enable;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_write_data;
  logic [DW-1:0] core_read_data;
  logic          core_read_ready, core_write_ready;
  logic          error_clear, stats_clear;
  logic          timeout_error;
  logic [CW-1:0] read_count, write_count;

  dijkstra_mem_bridge_if #(.MADDR_WIDTH(AW), .MDATA_WIDTH(DW)) bus ();

  dijkstra_mem_bridge #(
    .MADDR_WIDTH(AW), .MDATA_WIDTH(DW), .TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)
  ) dut (
    .algorithm_clock  (algorithm_clock),
    .algorithm_reset  (algorithm_reset),
    .core_read_enable (core_read_enable),
    .core_write_enable(core_write_enable),
    .core_addr        (core_addr),
    .core_write_data  (core_write_data),
    .core_read_data   (core_read_data),
    .core_read_ready  (core_read_ready),
    .core_write_ready (core_write_ready),
    .avm              (bus),
    .error_clear      (error_clear),
    .stats_clear      (stats_clear),
    .timeout_error    (timeout_error),
    .read_count       (read_count),
    .write_count      (write_count)
  );

  initial forever #5 algorithm_clock = ~algorithm_clock;

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    exp_rd = 0;
  int    exp_wr = 0;
  int    c0;
  resp_t exp_q[$];

  always @(posedge algorithm_clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge algorithm_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input bit is_read, input logic [15:0] data, input int cycle);
    resp_t e;
    e.is_read = is_read;
    e.data    = data;
    e.cycle   = cycle;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for a ready pulse, compares it with the scoreboard head, then behaves like the
  // core: drops the request in the ready cycle and checks the counters one cycle later.
  task automatic wait_resp(input string tag, input bit clr_stats);
    resp_t e;
    bit    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      seen = core_read_ready || core_write_ready;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (!seen) return;
    check({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, "_kind"}, {core_read_ready, core_write_ready}, e.is_read ? 64'b10 : 64'b01);
    check({tag, "_cycle"}, 64'(cyc), 64'(e.cycle));
    check({tag, "_cmd_dropped"}, {bus.read, bus.write}, 64'd0);
    if (e.is_read) begin
      check({tag, "_rdata"}, 64'(core_read_data), 64'(e.data));
      exp_rd++;
      core_read_enable = 1'b0;
    end else begin
      exp_wr++;
      core_write_enable = 1'b0;
    end
    bus.readdatavalid = 1'b0;
    error_clear       = 1'b0;
    stats_clear       = clr_stats;
    if (clr_stats) begin
      exp_rd = 0;
      exp_wr = 0;
    end
    tick();
    stats_clear = 1'b0;
    check({tag, "_pulse_len"}, {core_read_ready, core_write_ready}, 64'd0);
    check({tag, "_read_count"}, 64'(read_count), 64'(exp_rd));
    check({tag, "_write_count"}, 64'(write_count), 64'(exp_wr));
  endtask

  initial begin
    algorithm_reset   = 1'b1;
    core_read_enable  = 1'b0;
    core_write_enable = 1'b0;
    core_addr         = '0;
    core_write_data   = '0;
    error_clear       = 1'b0;
    stats_clear       = 1'b0;
    bus.waitrequest   = 1'b0;
    bus.readdata      = '0;
    bus.readdatavalid = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_cmds", {bus.read, bus.write}, 64'd0);
    check("rst_addr", 64'(bus.address), 64'd0);
    check("rst_be", 64'(bus.byteenable), 64'd0);
    check("rst_ready", {core_read_ready, core_write_ready}, 64'd0);
    check("rst_rdata", 64'(core_read_data), 64'd0);
    check("rst_flags", {timeout_error, read_count, write_count}, 64'd0);
    algorithm_reset = 1'b0;
    tick();

    // Read, zero wait states
    c0 = cyc;
    core_read_enable = 1'b1;
    core_addr        = 32'h0000_1000;
    push(1'b1, 16'h00AB, c0 + 3);
    tick();
    check("rd0_read", 64'(bus.read), 64'd1);
    check("rd0_addr", 64'(bus.address), 64'h1000);
    check("rd0_be", 64'(bus.byteenable), 64'h3);
    tick();
    check("rd0_read_1cyc", {bus.read, bus.byteenable}, 64'd0);
    bus.readdata      = 16'h00AB;
    bus.readdatavalid = 1'b1;
    wait_resp("rd0", 1'b0);

    // Write with 3 waitrequest cycles
    c0 = cyc;
    core_write_enable = 1'b1;
    core_addr         = 32'h0000_2002;
    core_write_data   = 16'h1234;
    bus.waitrequest   = 1'b1;
    push(1'b0, 16'h0000, c0 + 5);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("wr3_hold%0d", i), {bus.write, bus.address, bus.writedata, bus.byteenable},
            {1'b1, 32'h0000_2002, 16'h1234, 2'b11});
      if (i == 4) bus.waitrequest = 1'b0;
    end
    wait_resp("wr3", 1'b0);

    // Simultaneous read and write: read first, write issued afterwards
    c0 = cyc;
    core_read_enable  = 1'b1;
    core_write_enable = 1'b1;
    core_addr         = 32'h0000_3000;
    core_write_data   = 16'h5555;
    push(1'b1, 16'hBEEF, c0 + 3);
    push(1'b0, 16'h0000, c0 + 6);
    tick();
    check("sim_read_first", {bus.read, bus.write}, 64'b10);
    tick();
    bus.readdata      = 16'hBEEF;
    bus.readdatavalid = 1'b1;
    wait_resp("sim_rd", 1'b0);
    check("sim_wr_not_yet", 64'(bus.write), 64'd0);
    tick();
    check("sim_wr_issue", {bus.write, bus.address, bus.writedata}, {1'b1, 32'h0000_3000, 16'h5555});
    wait_resp("sim_wr", 1'b0);

    // Read timeout with waitrequest stuck high
    c0 = cyc;
    core_read_enable = 1'b1;
    core_addr        = 32'h0000_4000;
    bus.waitrequest  = 1'b1;
    push(1'b1, 16'hFFFF, c0 + 9);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("to_rd_hold%0d", i), {bus.read, bus.address}, {1'b1, 32'h0000_4000});
    end
    wait_resp("to_rd", 1'b0);
    bus.waitrequest = 1'b0;
    check("to_rd_flag", 64'(timeout_error), 64'd1);
    bus.readdata      = 16'h1111;
    bus.readdatavalid = 1'b1;
    tick();
    bus.readdatavalid = 1'b0;
    check("to_late_rdv_data", 64'(core_read_data), 64'hFFFF);
    check("to_late_rdv_ready", {core_read_ready, core_write_ready, bus.read}, 64'd0);
    tick();
    check("to_late_rdv_count", 64'(read_count), 64'(exp_rd));
    error_clear = 1'b1;
    tick();
    error_clear = 1'b0;
    check("to_err_clear", 64'(timeout_error), 64'd0);

    // Write timeout with error_clear in the timeout cycle: the flag must stay set
    c0 = cyc;
    core_write_enable = 1'b1;
    core_addr         = 32'h0000_6000;
    core_write_data   = 16'hAAAA;
    bus.waitrequest   = 1'b1;
    push(1'b0, 16'h0000, c0 + 9);
    for (int i = 1; i <= 8; i++) begin
      tick();
      check($sformatf("to_wr_hold%0d", i), {bus.write, bus.writedata}, {1'b1, 16'hAAAA});
      if (i == 8) error_clear = 1'b1;
    end
    wait_resp("to_wr", 1'b0);
    bus.waitrequest = 1'b0;
    check("to_wr_flag_kept", 64'(timeout_error), 64'd1);

    // Reset in RD_DATA drops the command, no pulse, late readdatavalid ignored
    c0 = cyc;
    core_read_enable = 1'b1;
    core_addr        = 32'h0000_5000;
    tick();
    check("rstmid_read", 64'(bus.read), 64'd1);
    tick();
    algorithm_reset  = 1'b1;
    core_read_enable = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    tick();
    check("rstmid_cmds", {bus.read, bus.write, bus.byteenable}, 64'd0);
    check("rstmid_ready", {core_read_ready, core_write_ready}, 64'd0);
    check("rstmid_counts", {timeout_error, read_count, write_count}, 64'd0);
    algorithm_reset   = 1'b0;
    bus.readdata      = 16'h2222;
    bus.readdatavalid = 1'b1;
    tick();
    bus.readdatavalid = 1'b0;
    check("rstmid_late_rdv", {core_read_ready, core_write_ready, bus.read, core_read_data}, 64'd0);
    tick();
    check("rstmid_late_cnt", {read_count, write_count}, 64'd0);

    // stats_clear in the RESP cycle wins over the increment
    c0 = cyc;
    core_write_enable = 1'b1;
    core_addr         = 32'h0000_7000;
    core_write_data   = 16'h0F0F;
    push(1'b0, 16'h0000, c0 + 2);
    wait_resp("cnt_wr1", 1'b0);
    c0 = cyc;
    core_write_enable = 1'b1;
    push(1'b0, 16'h0000, c0 + 2);
    wait_resp("cnt_wr2_clear", 1'b1);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
